spatz_xmem_responder: RTL and testbench

Memory-side end of the X-interface memory channel. Spatz's load/store unit drives requests into this block, which checks them and forwards legal accesses to a TCDM-style SRAM port with in-order, variable-latency responses. Read data and completions come back as X-interface memory results. One instance serves one memory port; a cluster instantiates NrMemPorts copies.

---
 rtl/spatz_xmem_responder.sv | 175 +++++++++++++++++
 tb/tb_spatz_xmem_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spatz_xmem_responder.sv
// Memory-side responder for the Spatz X-interface memory channel: validates requests,
// forwards legal ones to an in-order SRAM port and returns results one cycle after each response.
module spatz_xmem_responder #(
  parameter int unsigned          AddrWidth      = 32,
  parameter int unsigned          DataWidth      = 32,
  parameter int unsigned          IdWidth        = 4,
  parameter int unsigned          MaxOutstanding = 4,
  parameter logic [AddrWidth-1:0] BaseAddr       = 32'h0,
  parameter logic [AddrWidth-1:0] MemSize        = 32'h10000,
  localparam int unsigned         BeWidth        = DataWidth / 8,
  localparam int unsigned         CntWidth       = $clog2(MaxOutstanding) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 x_mem_valid_i,
  output logic                 x_mem_ready_o,
  input  logic [AddrWidth-1:0] x_mem_addr_i,
  input  logic                 x_mem_we_i,
  input  logic [BeWidth-1:0]   x_mem_be_i,
  input  logic [DataWidth-1:0] x_mem_wdata_i,
  input  logic [IdWidth-1:0]   x_mem_id_i,
  output logic                 x_mem_resp_exc_o,
  output logic [5:0]           x_mem_resp_exccode_o,
  output logic                 x_mem_result_valid_o,
  output logic [IdWidth-1:0]   x_mem_result_id_o,
  output logic [DataWidth-1:0] x_mem_result_rdata_o,
  output logic                 x_mem_result_err_o,
  input  logic                 x_mem_finished_i,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic                 mem_we_o,
  output logic [BeWidth-1:0]   mem_be_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  input  logic                 mem_rsp_valid_i,
  input  logic [DataWidth-1:0] mem_rsp_rdata_i,
  input  logic                 mem_rsp_err_i,
  output logic [CntWidth-1:0]  outstanding_o,
  output logic                 proto_err_o
);

  localparam int unsigned          PtrWidth  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [CntWidth-1:0]  CntMax    = CntWidth'(MaxOutstanding);
  localparam logic [AddrWidth-1:0] AlignMask = AddrWidth'(BeWidth - 1);
  localparam logic [AddrWidth:0]   WinLo     = {1'b0, BaseAddr};
  localparam logic [AddrWidth:0]   WinHi     = {1'b0, BaseAddr} + {1'b0, MemSize};

  localparam logic [5:0] ExcLdMisal = 6'd4;
  localparam logic [5:0] ExcLdFault = 6'd5;
  localparam logic [5:0] ExcStMisal = 6'd6;
  localparam logic [5:0] ExcStFault = 6'd7;

  logic [IdWidth-1:0]   fifo_id_q [MaxOutstanding];
  logic                 fifo_we_q [MaxOutstanding];
  logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0]  count_q, count_d;
  logic                 res_valid_q, res_valid_d;
  logic [IdWidth-1:0]   res_id_q, res_id_d;
  logic [DataWidth-1:0] res_rdata_q, res_rdata_d;
  logic                 res_err_q, res_err_d;
  logic                 proto_err_q, proto_err_d;

  logic       misaligned, oor, bad, full, empty, push, pop, violation;
  logic [5:0] exccode;

  // Request classification and exception code (misalignment has priority)
  always_comb begin
    misaligned = (x_mem_addr_i & AlignMask) != '0;
    oor        = ({1'b0, x_mem_addr_i} < WinLo) || ({1'b0, x_mem_addr_i} >= WinHi);
    bad        = misaligned | oor;
    full       = (count_q == CntMax);
    empty      = (count_q == '0);
    if (misaligned) begin
      exccode = x_mem_we_i ? ExcStMisal : ExcLdMisal;
    end else if (oor) begin
      exccode = x_mem_we_i ? ExcStFault : ExcLdFault;
    end else begin
      exccode = 6'd0;
    end
  end

  assign mem_req_valid_o      = x_mem_valid_i & ~bad & ~full;
  assign mem_addr_o           = x_mem_addr_i;
  assign mem_we_o             = x_mem_we_i;
  assign mem_be_o             = x_mem_be_i;
  assign mem_wdata_o          = x_mem_wdata_i;
  // Ready deliberately ignores a same-cycle pop to keep the path short
  assign x_mem_ready_o        = ~full & (bad | mem_req_ready_i);
  assign x_mem_resp_exc_o     = bad;
  assign x_mem_resp_exccode_o = exccode;

  assign push      = x_mem_valid_i & ~full & ~bad & mem_req_ready_i;
  assign pop       = mem_rsp_valid_i & ~empty;
  assign violation = (mem_rsp_valid_i & empty) |
                     (x_mem_finished_i & (~empty | res_valid_q));

  // Next-state for pointers, count, result stage and sticky error
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    res_valid_d = 1'b0;
    res_id_d    = '0;
    res_rdata_d = '0;
    res_err_d   = 1'b0;
    proto_err_d = proto_err_q | violation;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrWidth'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PtrWidth'(1);
      res_valid_d = 1'b1;
      res_id_d    = fifo_id_q[rd_ptr_q];
      res_rdata_d = fifo_we_q[rd_ptr_q] ? '0 : mem_rsp_rdata_i;
      res_err_d   = mem_rsp_err_i;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntWidth'(1);
      2'b01:   count_d = count_q - CntWidth'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_rdata_q <= '0;
      res_err_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_rdata_q <= res_rdata_d;
      res_err_q   <= res_err_d;
      proto_err_q <= proto_err_d;
    end
  end

  // In-flight {id, we} storage
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < MaxOutstanding; i++) begin
        fifo_id_q[i] <= '0;
        fifo_we_q[i] <= 1'b0;
      end
    end else if (push) begin
      fifo_id_q[wr_ptr_q] <= x_mem_id_i;
      fifo_we_q[wr_ptr_q] <= x_mem_we_i;
    end else begin
      fifo_id_q[wr_ptr_q] <= fifo_id_q[wr_ptr_q];
      fifo_we_q[wr_ptr_q] <= fifo_we_q[wr_ptr_q];
    end
  end

  assign x_mem_result_valid_o = res_valid_q;
  assign x_mem_result_id_o    = res_id_q;
  assign x_mem_result_rdata_o = res_rdata_q;
  assign x_mem_result_err_o   = res_err_q;
  assign outstanding_o        = count_q;
  assign proto_err_o          = proto_err_q;

endmodule

// File: tb/tb_spatz_xmem_responder.sv
// Directed bench for spatz_xmem_responder: handshake, exceptions, back-pressure,
// in-order results and protocol-violation flag.
module tb_spatz_xmem_responder;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        x_mem_valid_i;
  logic        x_mem_ready_o;
  logic [31:0] x_mem_addr_i;
  logic        x_mem_we_i;
  logic [3:0]  x_mem_be_i;
  logic [31:0] x_mem_wdata_i;
  logic [3:0]  x_mem_id_i;
  logic        x_mem_resp_exc_o;
  logic [5:0]  x_mem_resp_exccode_o;
  logic        x_mem_result_valid_o;
  logic [3:0]  x_mem_result_id_o;
  logic [31:0] x_mem_result_rdata_o;
  logic        x_mem_result_err_o;
  logic        x_mem_finished_i;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rsp_valid_i;
  logic [31:0] mem_rsp_rdata_i;
  logic        mem_rsp_err_i;
  logic [2:0]  outstanding_o;
  logic        proto_err_o;

  int n_checks = 0;
  int n_errors = 0;

  spatz_xmem_responder dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .x_mem_valid_i(x_mem_valid_i), .x_mem_ready_o(x_mem_ready_o),
    .x_mem_addr_i(x_mem_addr_i), .x_mem_we_i(x_mem_we_i), .x_mem_be_i(x_mem_be_i),
    .x_mem_wdata_i(x_mem_wdata_i), .x_mem_id_i(x_mem_id_i),
    .x_mem_resp_exc_o(x_mem_resp_exc_o), .x_mem_resp_exccode_o(x_mem_resp_exccode_o),
    .x_mem_result_valid_o(x_mem_result_valid_o), .x_mem_result_id_o(x_mem_result_id_o),
    .x_mem_result_rdata_o(x_mem_result_rdata_o), .x_mem_result_err_o(x_mem_result_err_o),
    .x_mem_finished_i(x_mem_finished_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_rdata_i(mem_rsp_rdata_i),
    .mem_rsp_err_i(mem_rsp_err_i),
    .outstanding_o(outstanding_o), .proto_err_o(proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic req(input logic [31:0] addr, input logic we, input logic [3:0] id);
    x_mem_valid_i = 1'b1;
    x_mem_addr_i  = addr;
    x_mem_we_i    = we;
    x_mem_id_i    = id;
    x_mem_wdata_i = 32'h5A5A_0000 | {28'd0, id};
    #1;
  endtask

  initial begin
    rst_ni = 1'b0; x_mem_valid_i = 1'b0; x_mem_addr_i = 32'd0; x_mem_we_i = 1'b0;
    x_mem_be_i = 4'hF; x_mem_wdata_i = 32'd0; x_mem_id_i = 4'd0; x_mem_finished_i = 1'b0;
    mem_req_ready_i = 1'b1; mem_rsp_valid_i = 1'b0; mem_rsp_rdata_i = 32'd0; mem_rsp_err_i = 1'b0;
    tick(); tick();
    chk("rst_result_valid", 64'(x_mem_result_valid_o), 64'd0);
    chk("rst_outstanding", 64'(outstanding_o), 64'd0);
    chk("rst_proto_err", 64'(proto_err_o), 64'd0);
    chk("rst_mem_req_valid", 64'(mem_req_valid_o), 64'd0);
    rst_ni = 1'b1;
    tick();

    // Single load, response two cycles later
    req(32'h100, 1'b0, 4'd3);
    chk("ld_ready", 64'(x_mem_ready_o), 64'd1);
    chk("ld_exc", 64'(x_mem_resp_exc_o), 64'd0);
    chk("ld_exccode", 64'(x_mem_resp_exccode_o), 64'd0);
    chk("ld_mem_req_valid", 64'(mem_req_valid_o), 64'd1);
    chk("ld_mem_addr", 64'(mem_addr_o), 64'h100);
    tick();
    x_mem_valid_i = 1'b0;
    chk("ld_outstanding_1", 64'(outstanding_o), 64'd1);
    tick();
    mem_rsp_valid_i = 1'b1; mem_rsp_rdata_i = 32'hDEADBEEF;
    #1;
    chk("ld_no_early_result", 64'(x_mem_result_valid_o), 64'd0);
    tick();
    mem_rsp_valid_i = 1'b0;
    chk("ld_result_valid", 64'(x_mem_result_valid_o), 64'd1);
    chk("ld_result_id", 64'(x_mem_result_id_o), 64'd3);
    chk("ld_result_rdata", 64'(x_mem_result_rdata_o), 64'hDEADBEEF);
    chk("ld_result_err", 64'(x_mem_result_err_o), 64'd0);
    chk("ld_outstanding_0", 64'(outstanding_o), 64'd0);
    tick();
    chk("ld_result_one_pulse", 64'(x_mem_result_valid_o), 64'd0);

    // Exceptions: misaligned store, out-of-range load
    req(32'h102, 1'b1, 4'd1);
    chk("st_mis_ready", 64'(x_mem_ready_o), 64'd1);
    chk("st_mis_exc", 64'(x_mem_resp_exc_o), 64'd1);
    chk("st_mis_code", 64'(x_mem_resp_exccode_o), 64'd6);
    chk("st_mis_mem_req", 64'(mem_req_valid_o), 64'd0);
    tick();
    req(32'h10000, 1'b0, 4'd2);
    chk("ld_oor_exc", 64'(x_mem_resp_exc_o), 64'd1);
    chk("ld_oor_code", 64'(x_mem_resp_exccode_o), 64'd5);
    chk("ld_oor_ready", 64'(x_mem_ready_o), 64'd1);
    tick();
    req(32'h10001, 1'b1, 4'd2);
    chk("st_mis_oor_code", 64'(x_mem_resp_exccode_o), 64'd6);
    req(32'hFFFC, 1'b1, 4'd2);
    chk("st_last_word_exc", 64'(x_mem_resp_exc_o), 64'd0);
    x_mem_valid_i = 1'b0;
    req(32'h10004, 1'b1, 4'd2);
    chk("st_oor_code", 64'(x_mem_resp_exccode_o), 64'd7);
    req(32'h103, 1'b0, 4'd2);
    chk("ld_mis_code", 64'(x_mem_resp_exccode_o), 64'd4);
    x_mem_valid_i = 1'b0;
    tick();
    chk("bad_no_entry", 64'(outstanding_o), 64'd0);
    chk("bad_no_result", 64'(x_mem_result_valid_o), 64'd0);

    // SRAM stall: no push without grant
    mem_req_ready_i = 1'b0;
    req(32'h200, 1'b0, 4'd9);
    chk("stall_ready", 64'(x_mem_ready_o), 64'd0);
    tick();
    chk("stall_no_push", 64'(outstanding_o), 64'd0);
    mem_req_ready_i = 1'b1;
    x_mem_valid_i = 1'b0;

    // Fill FIFO with ids 0..3, id 4 must stall
    for (int i = 0; i < 4; i++) begin
      req(32'h400 + 32'(4 * i), 1'b0, 4'(i));
      chk("fill_ready", 64'(x_mem_ready_o), 64'd1);
      tick();
    end
    req(32'h410, 1'b0, 4'd4);
    chk("full_ready", 64'(x_mem_ready_o), 64'd0);
    chk("full_outstanding", 64'(outstanding_o), 64'd4);
    chk("full_mem_req", 64'(mem_req_valid_o), 64'd0);
    mem_rsp_valid_i = 1'b1; mem_rsp_rdata_i = 32'h0000_00A0; mem_rsp_err_i = 1'b0;
    #1;
    chk("full_pop_no_bypass", 64'(x_mem_ready_o), 64'd0);
    tick();
    mem_rsp_valid_i = 1'b0;
    chk("pop0_id", 64'(x_mem_result_id_o), 64'd0);
    chk("pop0_rdata", 64'(x_mem_result_rdata_o), 64'hA0);
    chk("pop0_outstanding", 64'(outstanding_o), 64'd3);
    chk("after_pop_ready", 64'(x_mem_ready_o), 64'd1);
    tick();
    x_mem_valid_i = 1'b0;
    chk("id4_accepted", 64'(outstanding_o), 64'd4);

    // Back-to-back responses, error on id 2; pointers wrap here
    for (int k = 0; k < 4; k++) begin
      mem_rsp_valid_i = 1'b1;
      mem_rsp_rdata_i = 32'h1000 + 32'(k);
      mem_rsp_err_i   = (k == 1);
      tick();
      chk("b2b_valid", 64'(x_mem_result_valid_o), 64'd1);
      chk("b2b_id", 64'(x_mem_result_id_o), 64'(k + 1));
      chk("b2b_rdata", 64'(x_mem_result_rdata_o), 64'h1000 + 64'(k));
      chk("b2b_err", 64'(x_mem_result_err_o), (k == 1) ? 64'd1 : 64'd0);
    end
    mem_rsp_valid_i = 1'b0; mem_rsp_err_i = 1'b0;
    chk("b2b_drained", 64'(outstanding_o), 64'd0);
    chk("b2b_no_proto", 64'(proto_err_o), 64'd0);

    // Store result returns zero data
    req(32'h300, 1'b1, 4'd5);
    tick();
    x_mem_valid_i = 1'b0;
    mem_rsp_valid_i = 1'b1; mem_rsp_rdata_i = 32'hFFFF_FFFF;
    tick();
    mem_rsp_valid_i = 1'b0;
    chk("st_result_id", 64'(x_mem_result_id_o), 64'd5);
    chk("st_result_rdata", 64'(x_mem_result_rdata_o), 64'd0);

    // Response with empty FIFO
    tick();
    mem_rsp_valid_i = 1'b1; mem_rsp_rdata_i = 32'h1234;
    tick();
    mem_rsp_valid_i = 1'b0;
    chk("orphan_no_result", 64'(x_mem_result_valid_o), 64'd0);
    chk("orphan_proto", 64'(proto_err_o), 64'd1);
    chk("orphan_count", 64'(outstanding_o), 64'd0);
    tick(); tick();
    chk("proto_sticky", 64'(proto_err_o), 64'd1);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    chk("proto_cleared", 64'(proto_err_o), 64'd0);

    // finished with nothing in flight is legal
    x_mem_finished_i = 1'b1;
    tick();
    x_mem_finished_i = 1'b0;
    chk("fin_idle_ok", 64'(proto_err_o), 64'd0);

    // finished during the result cycle is a violation
    req(32'h500, 1'b0, 4'd6);
    tick();
    x_mem_valid_i = 1'b0;
    mem_rsp_valid_i = 1'b1; mem_rsp_rdata_i = 32'h55;
    tick();
    mem_rsp_valid_i = 1'b0;
    x_mem_finished_i = 1'b1;
    chk("fin_res_cycle_valid", 64'(x_mem_result_valid_o), 64'd1);
    tick();
    x_mem_finished_i = 1'b0;
    chk("fin_during_result", 64'(proto_err_o), 64'd1);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;

    // finished with one outstanding, then reset drops it
    req(32'h600, 1'b0, 4'd7);
    tick();
    x_mem_valid_i = 1'b0;
    chk("fin_out1_count", 64'(outstanding_o), 64'd1);
    chk("fin_out1_pre", 64'(proto_err_o), 64'd0);
    x_mem_finished_i = 1'b1;
    tick();
    x_mem_finished_i = 1'b0;
    chk("fin_outstanding", 64'(proto_err_o), 64'd1);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    chk("rst_drops_inflight", 64'(outstanding_o), 64'd0);
    mem_rsp_valid_i = 1'b1;
    tick();
    mem_rsp_valid_i = 1'b0;
    chk("late_rsp_no_result", 64'(x_mem_result_valid_o), 64'd0);
    chk("late_rsp_proto", 64'(proto_err_o), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
